// File: rtl/lcd_bus_responder.sv
// Receiver for a 4-bit HD44780-style character-LCD write bus. It decodes strobes into bytes,
// executes the commands, keeps a 2x16 DDRAM shadow with a registered read port, and flags timing faults.
module lcd_bus_responder #(
   parameter int MIN_E_HIGH   = 12,
   parameter int BUSY_CYCLES  = 2000,
   parameter int CLEAR_CYCLES = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_e,
   input  logic [3:0] lcd_d,
   input  logic [4:0] rd_idx,
   output logic [7:0] rd_char,
   output logic       byte_valid,
   output logic       byte_rs,
   output logic [7:0] byte_val,
   output logic [6:0] ddram_addr,
   output logic       mode_4bit,
   output logic       display_on,
   output logic       busy,
   output logic [3:0] err
);

   localparam int HW   = $clog2(MIN_E_HIGH + 1);
   localparam int BMAX = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
   localparam int BW   = $clog2(BMAX + 1);
   localparam logic [HW-1:0] HI_MAX     = HW'(MIN_E_HIGH);
   localparam logic [BW-1:0] BUSY_LOAD  = BW'(BUSY_CYCLES);
   localparam logic [BW-1:0] CLEAR_LOAD = BW'(CLEAR_CYCLES);

   logic          rs_q, rw_q, e_q, e_d;
   logic [3:0]    d_q;
   logic [HW-1:0] hi_cnt;
   logic          strobe;
   logic          phase_lo;
   logic [3:0]    hi_nib;
   logic          hi_rs;
   logic          err_rs, err_busy, err_short, err_rw;

   logic          cgram_sel, increment;
   logic [BW-1:0] busy_cnt;
   logic          fill_active;
   logic [4:0]    fill_idx;
   logic [7:0]    shadow [0:31];

   logic [6:0]    addr_nxt;
   logic          cgram_nxt, inc_nxt, mode_nxt, disp_nxt;
   logic          phase_rst, fill_start, wr_en;
   logic [4:0]    wr_idx;

   // Cursor step with the two-line DDRAM wrap; off-screen addresses step plainly.
   function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
      logic [6:0] r;
      if (up) begin
         if (a == 7'h27)      r = 7'h40;
         else if (a == 7'h67) r = 7'h00;
         else                 r = a + 7'd1;
      end else begin
         if (a == 7'h00)      r = 7'h67;
         else if (a == 7'h40) r = 7'h27;
         else                 r = a - 7'd1;
      end
      return r;
   endfunction

   assign strobe = e_d & ~e_q;
   assign busy   = (busy_cnt != '0);
   assign err    = {err_rs, err_busy, err_short, err_rw};

   // Bus sampling, pulse-width timing and nibble assembly into accepted bytes.
   always_ff @(posedge clk) begin
      if (reset) begin
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         e_q        <= 1'b0;
         e_d        <= 1'b0;
         d_q        <= 4'h0;
         hi_cnt     <= '0;
         phase_lo   <= 1'b0;
         hi_nib     <= 4'h0;
         hi_rs      <= 1'b0;
         byte_valid <= 1'b0;
         byte_rs    <= 1'b0;
         byte_val   <= 8'h00;
         err_rs     <= 1'b0;
         err_short  <= 1'b0;
         err_rw     <= 1'b0;
      end else begin
         rs_q       <= lcd_rs;
         rw_q       <= lcd_rw;
         e_q        <= lcd_e;
         d_q        <= lcd_d;
         e_d        <= e_q;
         byte_valid <= 1'b0;
         if (!e_q)
            hi_cnt <= '0;
         else if (hi_cnt != HI_MAX)
            hi_cnt <= hi_cnt + 1'b1;

         if (strobe) begin
            if (hi_cnt < HI_MAX) begin
               err_short <= 1'b1;
            end else if (rw_q) begin
               err_rw <= 1'b1;
            end else if (!mode_4bit) begin
               byte_valid <= 1'b1;
               byte_rs    <= rs_q;
               byte_val   <= {d_q, 4'h0};
            end else if (!phase_lo) begin
               phase_lo <= 1'b1;
               hi_nib   <= d_q;
               hi_rs    <= rs_q;
            end else begin
               phase_lo <= 1'b0;
               if (rs_q != hi_rs) begin
                  err_rs <= 1'b1;
               end else begin
                  byte_valid <= 1'b1;
                  byte_rs    <= rs_q;
                  byte_val   <= {hi_nib, d_q};
               end
            end
         end

         if (phase_rst)
            phase_lo <= 1'b0;
      end
   end

   // Byte execution: command decode by highest set bit, or a data write into DDRAM.
   always_comb begin
      addr_nxt   = ddram_addr;
      cgram_nxt  = cgram_sel;
      inc_nxt    = increment;
      mode_nxt   = mode_4bit;
      disp_nxt   = display_on;
      phase_rst  = 1'b0;
      fill_start = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = 5'd0;
      if (byte_valid) begin
         if (byte_rs) begin
            if (!cgram_sel) begin
               if (ddram_addr[6:4] == 3'b000) begin
                  wr_en  = 1'b1;
                  wr_idx = {1'b0, ddram_addr[3:0]};
               end else if (ddram_addr[6:4] == 3'b100) begin
                  wr_en  = 1'b1;
                  wr_idx = {1'b1, ddram_addr[3:0]};
               end
               addr_nxt = step_addr(ddram_addr, increment);
            end
         end else if (byte_val[7]) begin
            addr_nxt  = byte_val[6:0];
            cgram_nxt = 1'b0;
         end else if (byte_val[6]) begin
            cgram_nxt = 1'b1;
         end else if (byte_val[5]) begin
            mode_nxt  = ~byte_val[4];
            phase_rst = 1'b1;
         end else if (byte_val[4]) begin
            if (!byte_val[3])
               addr_nxt = step_addr(ddram_addr, byte_val[2]);
         end else if (byte_val[3]) begin
            disp_nxt = byte_val[2];
         end else if (byte_val[2]) begin
            inc_nxt = byte_val[1];
         end else if (byte_val[1]) begin
            addr_nxt  = 7'h00;
            cgram_nxt = 1'b0;
         end else if (byte_val[0]) begin
            addr_nxt   = 7'h00;
            cgram_nxt  = 1'b0;
            inc_nxt    = 1'b1;
            fill_start = 1'b1;
         end
      end
   end

   // Controller state, busy countdown and the clear-display fill sequencer.
   always_ff @(posedge clk) begin
      if (reset) begin
         ddram_addr  <= 7'h00;
         cgram_sel   <= 1'b0;
         increment   <= 1'b1;
         mode_4bit   <= 1'b0;
         display_on  <= 1'b0;
         busy_cnt    <= '0;
         err_busy    <= 1'b0;
         fill_active <= 1'b0;
         fill_idx    <= 5'd0;
      end else begin
         ddram_addr <= addr_nxt;
         cgram_sel  <= cgram_nxt;
         increment  <= inc_nxt;
         mode_4bit  <= mode_nxt;
         display_on <= disp_nxt;
         if (byte_valid) begin
            busy_cnt <= (!byte_rs && byte_val == 8'h01) ? CLEAR_LOAD : BUSY_LOAD;
            if (busy)
               err_busy <= 1'b1;
         end else if (busy) begin
            busy_cnt <= busy_cnt - 1'b1;
         end
         if (fill_start) begin
            fill_active <= 1'b1;
            fill_idx    <= 5'd0;
         end else if (fill_active) begin
            fill_idx <= fill_idx + 5'd1;
            if (fill_idx == 5'd31)
               fill_active <= 1'b0;
         end
      end
   end

   // Shadow screen; the read register sees the pre-write contents on a same-cycle write.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_char <= 8'h20;
         for (int i = 0; i < 32; i++)
            shadow[i] <= 8'h20;
      end else begin
         rd_char <= shadow[rd_idx];
         if (fill_active)
            shadow[fill_idx] <= 8'h20;
         else if (wr_en)
            shadow[wr_idx] <= byte_val;
      end
   end

endmodule
